// File: rtl/add_pkg.sv
// Shared types and constants for the calc/add multi-cycle adder family.
package add_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } add_state_t;

    localparam logic ADD_MODE_ADD = 1'b0;
    localparam logic ADD_MODE_SUB = 1'b1;

    // A single-chunk adder still needs a one-bit counter to index chunk 0.
    function automatic int cnt_width(input int num_chunks);
        return (num_chunks > 1) ? $clog2(num_chunks) : 1;
    endfunction

endpackage

// File: rtl/add_01bit_full.sv
// One-bit full adder cell: the building block of the chunk ripple adder.
module add_01bit_full (
    input  logic a,
    input  logic b,
    input  logic cry_in,
    output logic sum,
    output logic cry_out
);

    assign sum     = a ^ b ^ cry_in;
    assign cry_out = (a & b) | (cry_in & (a ^ b));

endmodule

// File: rtl/add_chunk.sv
// Combinational CHUNK_WIDTH-bit ripple adder made of add_01bit_full cells.
module add_chunk #(
    parameter int CHUNK_WIDTH = 8
) (
    input  logic [CHUNK_WIDTH-1:0] a,
    input  logic [CHUNK_WIDTH-1:0] b,
    input  logic                   cry_in,
    output logic [CHUNK_WIDTH-1:0] sum,
    output logic                   cry_out
);

    logic [CHUNK_WIDTH:0] cry;

    assign cry[0] = cry_in;

    for (genvar i = 0; i < CHUNK_WIDTH; i++) begin : g_bit
        add_01bit_full u_bit (
            .a      (a[i]),
            .b      (b[i]),
            .cry_in (cry[i]),
            .sum    (sum[i]),
            .cry_out(cry[i+1])
        );
    end

    assign cry_out = cry[CHUNK_WIDTH];

endmodule

// File: rtl/add_nbit_seq.sv
// Multi-cycle DATA_WIDTH adder/subtractor: one CHUNK_WIDTH slice per clock,
// carry held in a flop between slices, valid/ready handshake on both sides.
module add_nbit_seq
    import add_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_num_a,
    input  logic [DATA_WIDTH-1:0] i_num_b,
    input  logic                  i_cry,
    input  logic                  i_mode,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_res,
    output logic                  o_cry,
    output logic                  o_ovf
);

    localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int CNT_W      = cnt_width(NUM_CHUNKS);
    localparam int MSB        = DATA_WIDTH - 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    add_state_t state_q, state_d;

    logic [DATA_WIDTH-1:0]  a_q;
    logic [DATA_WIDTH-1:0]  b_q;
    logic [DATA_WIDTH-1:0]  res_q;
    logic                   carry_q;
    logic [CNT_W-1:0]       cnt_q;

    logic [CHUNK_WIDTH-1:0] chunk_a;
    logic [CHUNK_WIDTH-1:0] chunk_b;
    logic [CHUNK_WIDTH-1:0] chunk_sum;
    logic                   chunk_cry;
    logic                   is_sub;

    assign is_sub  = (i_mode == ADD_MODE_SUB);
    assign chunk_a = a_q[int'(cnt_q)*CHUNK_WIDTH +: CHUNK_WIDTH];
    assign chunk_b = b_q[int'(cnt_q)*CHUNK_WIDTH +: CHUNK_WIDTH];

    add_chunk #(
        .CHUNK_WIDTH(CHUNK_WIDTH)
    ) u_chunk (
        .a      (chunk_a),
        .b      (chunk_b),
        .cry_in (carry_q),
        .sum    (chunk_sum),
        .cry_out(chunk_cry)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_valid) state_d = CALC;
            CALC:    if (cnt_q == LAST_CHUNK) state_d = DONE;
            DONE:    if (i_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Subtraction is a + ~b + !borrow, so operand and carry are inverted once at capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        a_q     <= i_num_a;
                        b_q     <= is_sub ? ~i_num_b : i_num_b;
                        carry_q <= is_sub ? ~i_cry : i_cry;
                        cnt_q   <= '0;
                    end
                end
                CALC: begin
                    res_q[int'(cnt_q)*CHUNK_WIDTH +: CHUNK_WIDTH] <= chunk_sum;
                    carry_q <= chunk_cry;
                    if (cnt_q != LAST_CHUNK) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_valid = (state_q == DONE);
    assign o_res   = res_q;
    assign o_cry   = carry_q;
    // Overflow only means something once every chunk of the result is written.
    assign o_ovf   = o_valid && (a_q[MSB] == b_q[MSB]) && (res_q[MSB] != a_q[MSB]);

endmodule

// File: tb/tb_add_nbit_seq.sv
// Self-checking bench for add_nbit_seq: directed cases plus a randomized sweep
// on a 4-chunk and a single-chunk instance, checked against an arithmetic model.
module tb_add_nbit_seq;
    import add_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_cry;
    logic         in_mode;
    logic [W-1:0] num_a;
    logic [W-1:0] num_b;
    logic         use_wide;

    logic         rdy_n, val_n, cry_n, ovf_n;
    logic [W-1:0] res_n;
    logic         rdy_w, val_w, cry_w, ovf_w;
    logic [W-1:0] res_w;

    logic         sel_ready, sel_valid, sel_cry, sel_ovf;
    logic [W-1:0] sel_res;

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;

    add_nbit_seq #(
        .DATA_WIDTH (W),
        .CHUNK_WIDTH(8)
    ) dut_narrow (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_valid(in_valid & ~use_wide),
        .o_ready(rdy_n),
        .i_num_a(num_a),
        .i_num_b(num_b),
        .i_cry  (in_cry),
        .i_mode (in_mode),
        .o_valid(val_n),
        .i_ready(in_ready & ~use_wide),
        .o_res  (res_n),
        .o_cry  (cry_n),
        .o_ovf  (ovf_n)
    );

    add_nbit_seq #(
        .DATA_WIDTH (W),
        .CHUNK_WIDTH(32)
    ) dut_wide (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_valid(in_valid & use_wide),
        .o_ready(rdy_w),
        .i_num_a(num_a),
        .i_num_b(num_b),
        .i_cry  (in_cry),
        .i_mode (in_mode),
        .o_valid(val_w),
        .i_ready(in_ready & use_wide),
        .o_res  (res_w),
        .o_cry  (cry_w),
        .o_ovf  (ovf_w)
    );

    assign sel_ready = use_wide ? rdy_w : rdy_n;
    assign sel_valid = use_wide ? val_w : val_n;
    assign sel_res   = use_wide ? res_w : res_n;
    assign sel_cry   = use_wide ? cry_w : cry_n;
    assign sel_ovf   = use_wide ? ovf_w : ovf_n;

    // Reference: exact integer arithmetic, carry = unsigned result fits past bit 31,
    // overflow = signed result outside the 32-bit two's complement range.
    function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                      input logic cin, input logic mode,
                                      output logic [31:0] res, output logic cry,
                                      output logic ovf);
        longint ua, ub, sa, sb, usum, ssum;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (mode == ADD_MODE_ADD) begin
            usum = ua + ub + longint'(cin);
            ssum = sa + sb + longint'(cin);
            cry  = (usum > 64'sd4294967295);
        end else begin
            usum = ua - ub - longint'(cin);
            ssum = sa - sb - longint'(cin);
            cry  = (usum >= 0);
        end
        res = usum[31:0];
        ovf = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Issues one operation, scrambles the inputs during CALC, and counts cycles to o_valid.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic mode, output int lat);
        @(negedge clk);
        checkOutput("ready_before_issue", sel_ready, 1);
        num_a    = a;
        num_b    = b;
        in_cry   = cin;
        in_mode  = mode;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        num_a    = $urandom;
        num_b    = $urandom;
        in_mode  = ~mode;
        in_cry   = ~cin;
        lat = 0;
        while (!sel_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic checkResult(input string tag, input logic [31:0] exp_res,
                               input logic exp_cry, input logic exp_ovf,
                               input int exp_lat, input int lat);
        checkOutput({tag, "_latency"}, lat, exp_lat);
        checkOutput({tag, "_valid"}, sel_valid, 1);
        checkOutput({tag, "_ready_busy"}, sel_ready, 0);
        checkOutput({tag, "_res"}, sel_res, exp_res);
        checkOutput({tag, "_cry"}, sel_cry, exp_cry);
        checkOutput({tag, "_ovf"}, sel_ovf, exp_ovf);
    endtask

    task automatic ackResult();
        in_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_ready = 1'b0;
        checkOutput("valid_after_ack", sel_valid, 0);
        checkOutput("ready_after_ack", sel_ready, 1);
    endtask

    initial begin
        logic [31:0] a_v, b_v, exp_res, held_res;
        logic        cin_v, mode_v, exp_cry, exp_ovf, held_cry;
        int          lat;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_ready = 1'b0;
        in_cry   = 1'b0;
        in_mode  = ADD_MODE_ADD;
        num_a    = '0;
        num_b    = '0;
        use_wide = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ready", sel_ready, 1);
        checkOutput("reset_valid", sel_valid, 0);
        checkOutput("reset_res", sel_res, 0);
        checkOutput("reset_cry", sel_cry, 0);
        checkOutput("reset_ovf", sel_ovf, 0);
        rst_n = 1'b1;

        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, ADD_MODE_ADD, lat);
        checkResult("add_wrap", 32'h0000_0000, 1'b1, 1'b0, 4, lat);
        ackResult();

        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, ADD_MODE_ADD, lat);
        checkResult("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 4, lat);
        ackResult();

        applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b1, ADD_MODE_ADD, lat);
        checkResult("add_cin", 32'h2345_678A, 1'b0, 1'b0, 4, lat);
        ackResult();

        applyStimulus(32'd5, 32'd7, 1'b0, ADD_MODE_SUB, lat);
        checkResult("sub_neg", 32'hFFFF_FFFE, 1'b0, 1'b0, 4, lat);
        ackResult();

        applyStimulus(32'h8000_0000, 32'd1, 1'b0, ADD_MODE_SUB, lat);
        checkResult("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 4, lat);
        ackResult();

        // Backpressure: result must hold and a fresh request must be ignored.
        applyStimulus(32'h0F0F_0F0F, 32'h0101_0101, 1'b1, ADD_MODE_ADD, lat);
        checkResult("bp", 32'h1010_1011, 1'b0, 1'b0, 4, lat);
        held_res = 32'h1010_1011;
        held_cry = 1'b0;
        num_a    = 32'hDEAD_BEEF;
        num_b    = 32'h1234_5678;
        in_mode  = ADD_MODE_SUB;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("bp_valid_hold", sel_valid, 1);
            checkOutput("bp_res_hold", sel_res, held_res);
            checkOutput("bp_cry_hold", sel_cry, held_cry);
            checkOutput("bp_ready_low", sel_ready, 0);
        end
        in_valid = 1'b0;
        ackResult();

        // Reset while chunk 2 is being computed.
        @(negedge clk);
        num_a    = 32'h1111_1111;
        num_b    = 32'h2222_2222;
        in_cry   = 1'b1;
        in_mode  = ADD_MODE_ADD;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_ready", sel_ready, 1);
        checkOutput("midrst_valid", sel_valid, 0);
        checkOutput("midrst_res", sel_res, 0);
        checkOutput("midrst_cry", sel_cry, 0);
        checkOutput("midrst_ovf", sel_ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(32'd3, 32'd4, 1'b0, ADD_MODE_ADD, lat);
        checkResult("post_rst", 32'd7, 1'b0, 1'b0, 4, lat);
        ackResult();

        for (int i = 0; i < 1000; i++) begin
            a_v    = pick_operand();
            b_v    = pick_operand();
            cin_v  = 1'($urandom_range(0, 1));
            mode_v = 1'($urandom_range(0, 1));
            ref_model(a_v, b_v, cin_v, mode_v, exp_res, exp_cry, exp_ovf);
            applyStimulus(a_v, b_v, cin_v, mode_v, lat);
            checkResult("rand_n", exp_res, exp_cry, exp_ovf, 4, lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ackResult();
        end

        use_wide = 1'b1;
        @(negedge clk);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, ADD_MODE_ADD, lat);
        checkResult("wide_add", 32'hFFFF_FFFE, 1'b1, 1'b0, 1, lat);
        ackResult();

        for (int i = 0; i < 200; i++) begin
            a_v    = pick_operand();
            b_v    = pick_operand();
            cin_v  = 1'($urandom_range(0, 1));
            mode_v = 1'($urandom_range(0, 1));
            ref_model(a_v, b_v, cin_v, mode_v, exp_res, exp_cry, exp_ovf);
            applyStimulus(a_v, b_v, cin_v, mode_v, lat);
            checkResult("rand_w", exp_res, exp_cry, exp_ovf, 1, lat);
            ackResult();
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
